sync_edge_detector: RTL and testbench

- Per-bit rising/falling edge detector for level signals in the clk domain.
- Registers the previous value of sig_in and compares it with the current value.
- Outputs are single-cycle pulses, valid in the same cycle the new level is presented (combinational from sig_in).
- Used wherever control logic needs one-cycle event strobes from level inputs.

---
 rtl/sync_edge_detector.sv | 62 ++++++
 tb/tb_sync_edge_detector.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sync_edge_detector.sv
// Per-bit rising/falling edge detector: one-cycle strobes from clk-synchronous levels.
// Optional bit-0 strobe counters (rise_cnt/fall_cnt) when EDGE_DETECTOR_CNT_EN is defined.

module sync_edge_lane #(
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse_p,
    output logic pulse_n
);
    logic sig_d;

    always_ff @(posedge clk) begin
        if (rst) sig_d <= RESET_LEVEL;
        else     sig_d <= sig;
    end

    // Masking with ~rst hides X on sig and suppresses in-flight pulses during reset.
    assign pulse_p =  sig & ~sig_d & ~rst;
    assign pulse_n = ~sig &  sig_d & ~rst;
endmodule

module sync_edge_detector #(
    parameter int WIDTH       = 1,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] pulse_out_p,
    output logic [WIDTH-1:0] pulse_out_n
`ifdef EDGE_DETECTOR_CNT_EN
    ,
    output logic [15:0]      rise_cnt,
    output logic [15:0]      fall_cnt
`endif
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sync_edge_lane #(.RESET_LEVEL(RESET_LEVEL)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .sig     (sig_in[i]),
            .pulse_p (pulse_out_p[i]),
            .pulse_n (pulse_out_n[i])
        );
    end

`ifdef EDGE_DETECTOR_CNT_EN
    // Counts the strobe at the edge where downstream logic samples it; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else begin
            if (pulse_out_p[0]) rise_cnt <= rise_cnt + 16'd1;
            if (pulse_out_n[0]) fall_cnt <= fall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sync_edge_detector.sv
// Directed bench for sync_edge_detector: WIDTH=4/RESET_LEVEL=0 main DUT, 1-bit RESET_LEVEL=1 side DUT.
module tb_sync_edge_detector;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sig_in;
    logic [W-1:0] pulse_out_p, pulse_out_n;
    logic         p1, n1;
    int           checks = 0;
    int           failures = 0;
    int           cnt_p, cnt_n;
`ifdef EDGE_DETECTOR_CNT_EN
    logic [15:0]  rise_cnt, fall_cnt, rise_cnt1, fall_cnt1;
`endif

    always #5 clk = ~clk;

    sync_edge_detector #(.WIDTH(W), .RESET_LEVEL(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .pulse_out_p (pulse_out_p),
        .pulse_out_n (pulse_out_n)
`ifdef EDGE_DETECTOR_CNT_EN
        ,
        .rise_cnt    (rise_cnt),
        .fall_cnt    (fall_cnt)
`endif
    );

    sync_edge_detector #(.WIDTH(1), .RESET_LEVEL(1'b1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in[0]),
        .pulse_out_p (p1),
        .pulse_out_n (n1)
`ifdef EDGE_DETECTOR_CNT_EN
        ,
        .rise_cnt    (rise_cnt1),
        .fall_cnt    (fall_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive at negedge, check the combinational outputs mid-cycle before the next posedge.
    task automatic step(input string tag, input logic [W-1:0] s, input logic r,
                        input logic [W-1:0] ep, input logic [W-1:0] en);
        @(negedge clk);
        sig_in = s;
        rst    = r;
        #1;
        chk({tag, "_p"}, 32'(pulse_out_p), 32'(ep));
        chk({tag, "_n"}, 32'(pulse_out_n), 32'(en));
        chk({tag, "_excl"}, 32'(pulse_out_p & pulse_out_n), 32'd0);
    endtask

    initial begin
        sig_in = 'x;
        rst    = 1'b1;

        // Reset held with input high: outputs masked, history X before first edge.
        for (int i = 0; i < 4; i++) begin
            step("rst_hold", 4'hF, 1'b1, 4'h0, 4'h0);
            chk("rst_hold_dut1", {30'd0, p1, n1}, 32'd0);
        end
        step("rst_rel", 4'hF, 1'b0, 4'hF, 4'h0);
        chk("rst_rel_dut1", {30'd0, p1, n1}, 32'd0);
        step("rst_rel2", 4'hF, 1'b0, 4'h0, 4'h0);

        // Rising edge after two low cycles
        step("rise0", 4'h0, 1'b0, 4'h0, 4'hF);
        step("rise1", 4'h0, 1'b0, 4'h0, 4'h0);
        step("rise2", 4'hF, 1'b0, 4'hF, 4'h0);
        step("rise3", 4'hF, 1'b0, 4'h0, 4'h0);

        // Falling edge after three high cycles
        step("fall0", 4'hF, 1'b0, 4'h0, 4'h0);
        step("fall1", 4'h0, 1'b0, 4'h0, 4'hF);
        step("fall2", 4'h0, 1'b0, 4'h0, 4'h0);

        // Repetition, starting from a fresh reset so counters start at 0
        step("rep_rst", 4'h0, 1'b1, 4'h0, 4'h0);
        cnt_p = 0;
        cnt_n = 0;
        for (int it = 0; it < 10; it++) begin
            for (int c = 0; c < 10; c++) begin
                logic [W-1:0] s, ep, en;
                s  = (c >= 2 && c < 6) ? 4'hF : 4'h0;
                ep = (c == 2) ? 4'hF : 4'h0;
                en = (c == 6) ? 4'hF : 4'h0;
                step("rep", s, 1'b0, ep, en);
                if (pulse_out_p[0] === 1'b1) cnt_p++;
                if (pulse_out_n[0] === 1'b1) cnt_n++;
            end
        end
        chk("rep_p_count", 32'(cnt_p), 32'd10);
        chk("rep_n_count", 32'(cnt_n), 32'd10);
`ifdef EDGE_DETECTOR_CNT_EN
        chk("rise_cnt", 32'(rise_cnt), 32'd10);
        chk("fall_cnt", 32'(fall_cnt), 32'd10);
`endif

        // Toggle 0101/1010 every cycle
        step("tog0", 4'h5, 1'b0, 4'h5, 4'h0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step("tog_a", 4'hA, 1'b0, 4'hA, 4'h5);
            else            step("tog_5", 4'h5, 1'b0, 4'h5, 4'hA);
        end

        // Mid-operation reset coinciding with a 0->1 transition
        step("mid0", 4'h0, 1'b0, 4'h0, 4'h5);
        step("mid1", 4'h0, 1'b0, 4'h0, 4'h0);
        step("mid_rst", 4'hF, 1'b1, 4'h0, 4'h0);
        step("mid_rel", 4'hF, 1'b0, 4'hF, 4'h0);
        chk("mid_rel_dut1", {30'd0, p1, n1}, 32'd0);
        step("mid_rel2", 4'hF, 1'b0, 4'h0, 4'h0);

        // Release with input low: RESET_LEVEL=1 instance must strobe falling
        step("rl1_rst", 4'h0, 1'b1, 4'h0, 4'h0);
        step("rl1_rel", 4'h0, 1'b0, 4'h0, 4'h0);
        chk("rl1_rel_dut1", {30'd0, p1, n1}, 32'd1);
        step("rl1_rel2", 4'h0, 1'b0, 4'h0, 4'h0);
        chk("rl1_rel2_dut1", {30'd0, p1, n1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
